// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: REQ -> WAIT -> VALID, sticky ERR.
// Optional accepted-instruction counter enabled by defining FETCH_COUNT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_DEPTH = 1024,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  output logic [31:0] pc_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  input  logic        instr_ready,
  output logic        fetch_err,
  output logic [1:0]  err_code,
  output logic [31:0] err_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_ERR} state_t;

  // 33-bit bounds so a top-of-memory region cannot wrap past 32'hFFFF_FFFC
  localparam logic [32:0] PC_LO   = {1'b0, RESET_PC};
  localparam logic [32:0] PC_HI   = {1'b0, RESET_PC} + (33'(IM_DEPTH) << 2) - 33'd4;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [1:0]  err_code_q;
  logic [31:0] err_pc_q;
  logic [7:0]  to_cnt;
  logic        npc_misaligned;
  logic        npc_out_of_range;

  always_comb begin
    npc_misaligned   = |npc_in[1:0];
    npc_out_of_range = ({1'b0, npc_in} < PC_LO) || ({1'b0, npc_in} > PC_HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      instr_q    <= '0;
      err_code_q <= '0;
      err_pc_q   <= '0;
      to_cnt     <= '0;
    end else begin
      unique case (state)
        S_REQ: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // a response on the last counted cycle wins over the timeout
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            state   <= S_VALID;
          end else if (to_cnt == TO_LAST) begin
            state      <= S_ERR;
            err_code_q <= 2'b10;
            err_pc_q   <= pc;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            if (npc_misaligned) begin
              state      <= S_ERR;
              err_code_q <= 2'b01;
              err_pc_q   <= npc_in;
            end else if (npc_out_of_range) begin
              state      <= S_ERR;
              err_code_q <= 2'b11;
              err_pc_q   <= npc_in;
            end else begin
              pc    <= npc_in;
              state <= S_REQ;
            end
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
      endcase
    end
  end

  assign pc_out      = pc;
  assign imem_addr   = pc;
  assign imem_req    = (state == S_REQ);
  assign instr_valid = (state == S_VALID);
  assign instr_out   = instr_q;
  assign fetch_err   = (state == S_ERR);
  assign err_code    = err_code_q;
  assign err_pc      = err_pc_q;

`ifdef FETCH_COUNT_EN
  logic        accept_ok;
  logic [31:0] count_q;

  assign accept_ok = (state == S_VALID) && instr_ready && !npc_misaligned && !npc_out_of_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          count_q <= '0;
    else if (accept_ok) count_q <= count_q + 32'd1;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: transaction-level model compared every cycle,
// plus hand-computed literal checks for latency, error codes and counters.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int unsigned IM_DEPTH = 1024;
  localparam int unsigned TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] npc_in = '0;
  logic [31:0] pc_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        instr_ready = 1'b0;
  logic        fetch_err;
  logic [1:0]  err_code;
  logic [31:0] err_pc;
  logic [31:0] fetch_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IM_DEPTH(IM_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .npc_in(npc_in), .pc_out(pc_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_ready(instr_ready), .fetch_err(fetch_err), .err_code(err_code),
    .err_pc(err_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an outstanding fetch is "issued", then "waiting" for a reply,
  // then "holding" an instruction until decode takes it.
  logic [31:0] m_pc, m_instr, m_errpc, m_count;
  logic [1:0]  m_code;
  bit          m_issue, m_waiting, m_holding, m_err;
  int          m_waited;

  function automatic bit in_range(input logic [31:0] a);
    return (longint'(a) >= longint'(RESET_PC)) &&
           (longint'(a) <= longint'(RESET_PC) + 4 * longint'(IM_DEPTH) - 4);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= RESET_PC; m_instr <= '0; m_errpc <= '0; m_count <= '0; m_code <= '0;
      m_issue <= 1'b1; m_waiting <= 1'b0; m_holding <= 1'b0; m_err <= 1'b0; m_waited <= 0;
    end else if (m_err) begin
      m_err <= 1'b1;
    end else if (m_issue) begin
      m_issue <= 1'b0; m_waiting <= 1'b1; m_waited <= 0;
    end else if (m_waiting) begin
      if (imem_rvalid) begin
        m_instr <= imem_rdata; m_waiting <= 1'b0; m_holding <= 1'b1;
      end else if (m_waited + 1 == int'(TIMEOUT)) begin
        m_waiting <= 1'b0; m_err <= 1'b1; m_code <= 2'b10; m_errpc <= m_pc;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (m_holding && instr_ready) begin
      m_holding <= 1'b0;
      if (npc_in[1:0] != 2'b00) begin
        m_err <= 1'b1; m_code <= 2'b01; m_errpc <= npc_in;
      end else if (!in_range(npc_in)) begin
        m_err <= 1'b1; m_code <= 2'b11; m_errpc <= npc_in;
      end else begin
        m_pc <= npc_in; m_issue <= 1'b1;
`ifdef FETCH_COUNT_EN
        m_count <= m_count + 32'd1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("pc_out",      pc_out,              m_pc);
      chk("imem_addr",   imem_addr,           m_pc);
      chk("imem_req",    {31'd0, imem_req},   {31'd0, m_issue});
      chk("instr_valid", {31'd0, instr_valid},{31'd0, m_holding});
      chk("instr_out",   instr_out,           m_instr);
      chk("fetch_err",   {31'd0, fetch_err},  {31'd0, m_err});
      chk("err_code",    {30'd0, err_code},   {30'd0, m_code});
      chk("err_pc",      err_pc,              m_errpc);
      chk("fetch_count", fetch_count,         m_count);
    end
  end

  // One instruction: reply lat cycles after the request, accept rdy cycles after valid.
  task automatic fetch_one(input int lat, input int rdy, input logic [31:0] data,
                           input logic [31:0] npc, input bit stale);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (imem_req !== 1'b1) begin
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      return;
    end
    imem_rvalid = stale; imem_rdata = $urandom;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    repeat (lat - 1) @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = data;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    repeat (rdy) begin npc_in = $urandom; @(negedge clk); end
    instr_ready = 1'b1; npc_in = npc;
    @(negedge clk);
    instr_ready = 1'b0; npc_in = $urandom;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rst_pc",  pc_out, RESET_PC);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    reset = 1'b0;

    // basic 3-cycle fetch
    chk("t1_req0",  {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0000_3000);
    fetch_one(1, 0, 32'h2008_0005, 32'h0000_3004, 1'b0);
    chk("t1_pc3",    pc_out, 32'h0000_3004);
    chk("t1_req3",   {31'd0, imem_req}, 32'd1);
    chk("t1_instr",  instr_out, 32'h2008_0005);

    // slow memory and slow decode
    fetch_one(5, 3, 32'hA5A5_0001, 32'h0000_3008, 1'b0);
    chk("t2_pc", pc_out, 32'h0000_3008);

    // misaligned next PC, then inputs ignored in ERR
    fetch_one(1, 0, 32'h1111_2222, 32'h0000_3006, 1'b0);
    chk("t3_err",   {31'd0, fetch_err}, 32'd1);
    chk("t3_code",  {30'd0, err_code}, 32'd1);
    chk("t3_errpc", err_pc, 32'h0000_3006);
    chk("t3_pc",    pc_out, 32'h0000_3008);
    imem_rvalid = 1'b1; instr_ready = 1'b1; npc_in = 32'h0000_3010;
    repeat (4) @(negedge clk);
    imem_rvalid = 1'b0; instr_ready = 1'b0;
    chk("t3_req_hold", {31'd0, imem_req}, 32'd0);

    // range checks
    apply_reset();
    fetch_one(1, 0, 32'h0000_0013, 32'h0000_4000, 1'b0);
    chk("t4_code",  {30'd0, err_code}, 32'd3);
    chk("t4_errpc", err_pc, 32'h0000_4000);
    apply_reset();
    fetch_one(2, 1, 32'h0000_0033, 32'h0000_3FFC, 1'b0);
    chk("t4_pc_top", pc_out, 32'h0000_3FFC);
    chk("t4_noerr",  {31'd0, fetch_err}, 32'd0);
    fetch_one(1, 0, 32'h0000_0044, 32'h0000_2FFC, 1'b0);
    chk("t4_code_lo", {30'd0, err_code}, 32'd3);
    apply_reset();
    fetch_one(1, 0, 32'h0000_0055, 32'hFFFF_FFFC, 1'b0);
    chk("t4_code_wrap", {30'd0, err_code}, 32'd3);

    // timeout after exactly 16 WAIT cycles
    apply_reset();
    repeat (16) @(negedge clk);
    chk("t5_not_yet", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    chk("t5_err",   {31'd0, fetch_err}, 32'd1);
    chk("t5_code",  {30'd0, err_code}, 32'd2);
    chk("t5_errpc", err_pc, 32'h0000_3000);
    apply_reset();
    fetch_one(16, 0, 32'hBEEF_0016, 32'h0000_3004, 1'b0);
    chk("t5_late_ok", {31'd0, fetch_err}, 32'd0);
    chk("t5_late_instr", instr_out, 32'hBEEF_0016);

    // reset during WAIT, stale reply right after release
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_pc_now", pc_out, 32'h0000_3000);
    reset = 1'b0;
    fetch_one(2, 0, 32'h0C0F_FEE1, 32'h0000_3004, 1'b1);
    fetch_one(1, 2, 32'h0C0F_FEE2, 32'h0000_3008, 1'b0);
    fetch_one(3, 0, 32'h0C0F_FEE3, 32'h0000_300C, 1'b0);
    chk("t6_pc", pc_out, 32'h0000_300C);
`ifdef FETCH_COUNT_EN
    chk("t6_count", fetch_count, 32'd3);
`else
    chk("t6_count", fetch_count, 32'd0);
`endif
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the CPU.
- Holds the current PC and drives it to the next-PC logic's oldPC input.
- Fetches the instruction at PC from a variable-latency instruction memory and presents it to decode with a valid/ready handshake.
- Loads the next-PC value when decode accepts the instruction; checks alignment, range and memory timeout, entering a sticky error state on a violation.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_DEPTH, 1024, instruction memory size in 32-bit words; legal PCs are RESET_PC to RESET_PC+4*IM_DEPTH-4.
- TIMEOUT, 16, maximum WAIT cycles before a timeout error (legal range 1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- npc_in  in  32  next PC from next-PC logic, sampled only on an accept.
- pc_out  out  32  current PC register; feeds next-PC oldPC.
- imem_req  out  1  one-cycle fetch request strobe.
- imem_addr  out  32  fetch address; equals pc_out.
- imem_rvalid  in  1  memory response valid.
- imem_rdata  in  32  memory response data.
- instr_valid  out  1  instruction available to decode.
- instr_out  out  32  captured instruction.
- instr_ready  in  1  decode accepts the instruction.
- fetch_err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 misaligned, 10 timeout, 11 out of range.
- err_pc  out  32  address that caused the error.
- fetch_count  out  32  accepted-instruction counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_PC, state=REQ.
  - instr_out=0, instr_valid=0, fetch_err=0, err_code=00, err_pc=0, fetch_count=0, timeout counter=0.
  - imem_req is combinational from state, so it is 1 while reset is held.
- Four states, with imem_req=1 only in REQ and instr_valid=1 only in VALID:
  - REQ:
    - Drive imem_addr=pc.
    - Next state WAIT; timeout counter cleared.
    - An imem_rvalid in this state is ignored (stale response).
  - WAIT:
    - If imem_rvalid=1: instr_out<=imem_rdata, next state VALID. The earliest response is the cycle after REQ.
    - Otherwise: counter increments. When the counter equals TIMEOUT-1 and imem_rvalid=0, next state ERR with err_code=10 and err_pc=pc.
    - A response on the final counted cycle wins over timeout.
  - VALID:
    - instr_out is stable while instr_ready=0.
    - If instr_ready=1 (accept), npc_in is checked, in priority order:
      - npc_in[1:0]!=0: ERR, err_code=01.
      - npc_in outside the legal range: ERR, err_code=11.
      - Otherwise: pc<=npc_in, next state REQ, fetch_count increments.
    - On either error, err_pc<=npc_in and pc is unchanged.
  - ERR:
    - fetch_err=1; imem_req=0; instr_valid=0.
    - pc, err_code and err_pc hold.
    - Only reset exits this state; imem_rvalid and instr_ready are ignored.
- Throughput and latency:
  - Minimum 3 cycles per instruction: REQ, WAIT (with response), VALID (with ready).
  - pc_out changes only on an accept edge.
- The range check uses 33-bit arithmetic for the upper bound, so there is no wrap-around at 32'hFFFF_FFFC.
- Reset mid-WAIT: a late imem_rvalid arriving while the block is in REQ is ignored.

Optional Feature:
- Macro FETCH_COUNT_EN.
- When defined: fetch_count increments by 1 on each successful accept, wraps from 32'hFFFF_FFFF to 0, and is cleared by reset.
- When not defined: the counter logic is absent and fetch_count is constant 0.

Test Plan:
- Reset release; memory returns 32'h2008_0005 one cycle after the request; ready=1, npc_in=32'h3004:
  - imem_req at 0x3000 in cycle 0, instr_valid in cycle 2.
  - pc_out=0x3004 and a new request in cycle 3.
- Memory response delayed 5 cycles, decode ready delayed 3 cycles:
  - instr_out stays stable while waiting.
  - Exactly one request per instruction.
  - pc_out changes only on the accept edge.
- Accept with npc_in=32'h0000_3006:
  - fetch_err=1, err_code=01, err_pc=0x3006, pc_out unchanged.
  - imem_req stays 0 afterward.
- Accept with npc_in=32'h0000_4000 (IM_DEPTH=1024):
  - err_code=11, err_pc=0x4000.
  - The same test with npc_in=0x3FFC succeeds.
- imem_rvalid never asserts:
  - ERR entered after exactly 16 WAIT cycles, err_code=10, err_pc=0x3000.
  - A response on WAIT cycle 16 is captured instead, with no error.
- Reset asserted during WAIT, stale imem_rvalid the cycle after release:
  - pc_out=0x3000 immediately.
  - The stale response is ignored.
  - The fetch restarts normally.
  - fetch_count=0, and equals 3 after three accepts when FETCH_COUNT_EN is defined.
